game_ram_scheduler: RTL and testbench

GAME_RAM_SCHEDULER -- requirements
Module: game_ram_scheduler

---
 rtl/game_ram_scheduler.sv | 148 ++++++++++++++
 tb/tb_game_ram_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_ram_scheduler.sv
// Arbitrates one p1 writer and two readers (p2, vga) onto a single-port synchronous RAM.
// Tracks the highest written address plus one as word_count.
module game_ram_scheduler #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   input  logic              p2_req,
   input  logic [ADDR_W-1:0] p2_addr,
   output logic              p2_gnt,
   output logic              p2_rvalid,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DATA  = 2'd3;

   localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic              p1_gnt_q, p1_gnt_d;
   logic              p2_gnt_q, p2_gnt_d;
   logic              vga_gnt_q, vga_gnt_d;
   logic              p2_rvalid_q, p2_rvalid_d;
   logic              vga_rvalid_q, vga_rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic              ram_wren_q, ram_wren_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   // last_vga: 1 when vga was the last read served; sel_vga: owner of the read in flight
   logic              last_vga_q, last_vga_d;
   logic              sel_vga_q, sel_vga_d;

   logic              pick_vga;
   logic [ADDR_W:0]   p1_count;

   assign pick_vga = vga_req & (~p2_req | ~last_vga_q);
   assign p1_count = {1'b0, p1_addr} + CountOne;

   always_comb begin
      state_d       = state_q;
      p1_gnt_d      = 1'b0;
      p2_gnt_d      = 1'b0;
      vga_gnt_d     = 1'b0;
      p2_rvalid_d   = 1'b0;
      vga_rvalid_d  = 1'b0;
      ram_wren_d    = 1'b0;
      rdata_d       = rdata_q;
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      word_count_d  = word_count_q;
      last_vga_d    = last_vga_q;
      sel_vga_d     = sel_vga_q;

      case (state_q)
         S_IDLE: begin
            if (p1_req) begin
               state_d       = S_WRITE;
               p1_gnt_d      = 1'b1;
               ram_wren_d    = 1'b1;
               ram_address_d = p1_addr;
               ram_data_d    = p1_wdata;
               if (p1_count > word_count_q) begin
                  word_count_d = p1_count;
               end
            end else if (p2_req || vga_req) begin
               state_d       = S_READ;
               sel_vga_d     = pick_vga;
               last_vga_d    = pick_vga;
               p2_gnt_d      = ~pick_vga;
               vga_gnt_d     = pick_vga;
               ram_address_d = pick_vga ? vga_addr : p2_addr;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_READ:  state_d = S_DATA;
         S_DATA: begin
            // ram_q now holds the word addressed during S_READ
            rdata_d      = ram_q;
            p2_rvalid_d  = ~sel_vga_q;
            vga_rvalid_d = sel_vga_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         p1_gnt_q      <= 1'b0;
         p2_gnt_q      <= 1'b0;
         vga_gnt_q     <= 1'b0;
         p2_rvalid_q   <= 1'b0;
         vga_rvalid_q  <= 1'b0;
         rdata_q       <= '0;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         ram_wren_q    <= 1'b0;
         word_count_q  <= '0;
         last_vga_q    <= 1'b1;
         sel_vga_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         p1_gnt_q      <= p1_gnt_d;
         p2_gnt_q      <= p2_gnt_d;
         vga_gnt_q     <= vga_gnt_d;
         p2_rvalid_q   <= p2_rvalid_d;
         vga_rvalid_q  <= vga_rvalid_d;
         rdata_q       <= rdata_d;
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         ram_wren_q    <= ram_wren_d;
         word_count_q  <= word_count_d;
         last_vga_q    <= last_vga_d;
         sel_vga_q     <= sel_vga_d;
      end
   end

   assign p1_gnt      = p1_gnt_q;
   assign p2_gnt      = p2_gnt_q;
   assign vga_gnt     = vga_gnt_q;
   assign p2_rvalid   = p2_rvalid_q;
   assign vga_rvalid  = vga_rvalid_q;
   assign rdata       = rdata_q;
   assign ram_address = ram_address_q;
   assign ram_data    = ram_data_q;
   assign ram_wren    = ram_wren_q;
   assign word_count  = word_count_q;

endmodule

// File: tb/tb_game_ram_scheduler.sv
// Directed bench for game_ram_scheduler with a behavioural sync RAM and expected-value queues.
module tb_game_ram_scheduler;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 10;

   logic              clock = 1'b0;
   logic              reset;
   logic              p1_req, p2_req, vga_req;
   logic [ADDR_W-1:0] p1_addr, p2_addr, vga_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_gnt, p2_gnt, vga_gnt, p2_rvalid, vga_rvalid;
   logic [DATA_W-1:0] rdata, ram_data, ram_q;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_wren;
   logic [ADDR_W:0]   word_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [DATA_W-1:0] mem     [32];
   logic [DATA_W-1:0] exp_mem [32];
   int unsigned       exp_wc;
   logic [DATA_W-1:0] rd_q    [$];
   logic [2:0]        gnt_q   [$];

   always #5 clock = ~clock;

   // Behavioural single-port synchronous RAM
   always @(posedge clock) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
   end

   game_ram_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
      .p2_req(p2_req), .p2_addr(p2_addr), .p2_gnt(p2_gnt), .p2_rvalid(p2_rvalid),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
      .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q), .word_count(word_count)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnts"}, {29'd0, p1_gnt, p2_gnt, vga_gnt}, 32'd0);
      check({tag, "_rvalid"}, {30'd0, p2_rvalid, vga_rvalid}, 32'd0);
      check({tag, "_wren"}, {31'd0, ram_wren}, 32'd0);
      check({tag, "_rdata"}, {22'd0, rdata}, 32'd0);
      check({tag, "_addr"}, {27'd0, ram_address}, 32'd0);
      check({tag, "_data"}, {22'd0, ram_data}, 32'd0);
      check({tag, "_wc"}, {26'd0, word_count}, 32'd0);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_wc = 0;
   endtask

   // Issued from idle: gnt expected one cycle after the request is first sampled
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n = 0;
      p1_addr  = a;
      p1_wdata = d;
      p1_req   = 1'b1;
      exp_mem[a] = d;
      if (int'(a) + 1 > exp_wc) exp_wc = int'(a) + 1;
      do begin
         tick();
         n++;
      end while (!p1_gnt && n < 8);
      p1_req = 1'b0;
      check("wr_latency", n, 1);
      check("wr_wren", {31'd0, ram_wren}, 32'd1);
      check("wr_addr", {27'd0, ram_address}, {27'd0, a});
      check("wr_data", {22'd0, ram_data}, {22'd0, d});
      check("wr_wc", {26'd0, word_count}, exp_wc);
      tick();
      check("wr_gnt_pulse", {30'd0, p1_gnt, ram_wren}, 32'd0);
   endtask

   task automatic do_read(input logic is_vga, input logic [ADDR_W-1:0] a);
      int n = 0;
      logic [DATA_W-1:0] exp;
      rd_q.push_back(exp_mem[a]);
      if (is_vga) begin vga_addr = a; vga_req = 1'b1; end
      else begin p2_addr = a; p2_req = 1'b1; end
      do begin
         tick();
         n++;
      end while (!(p2_gnt || vga_gnt) && n < 8);
      p2_req  = 1'b0;
      vga_req = 1'b0;
      check("rd_gnt_latency", n, 1);
      check("rd_gnt_who", {30'd0, p2_gnt, vga_gnt}, is_vga ? 32'd1 : 32'd2);
      check("rd_wren", {31'd0, ram_wren}, 32'd0);
      check("rd_addr", {27'd0, ram_address}, {27'd0, a});
      n = 0;
      do begin
         tick();
         n++;
      end while (!(p2_rvalid || vga_rvalid) && n < 8);
      exp = rd_q.pop_front();
      check("rd_valid_latency", n, 2);
      check("rd_valid_who", {30'd0, p2_rvalid, vga_rvalid}, is_vga ? 32'd1 : 32'd2);
      check("rd_data", {22'd0, rdata}, {22'd0, exp});
      tick();
      check("rd_valid_pulse", {30'd0, p2_rvalid, vga_rvalid}, 32'd0);
      check("rd_data_hold", {22'd0, rdata}, {22'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [2:0] g, eg;
      p1_req = 1'b0; p2_req = 1'b0; vga_req = 1'b0;
      p1_addr = '0; p2_addr = '0; vga_addr = '0; p1_wdata = '0;
      do_reset();
      check_all_zero("reset");

      // Basic write then read-back by p2 and vga
      do_write(5'd3, 10'h155);
      do_read(1'b0, 5'd3);
      do_write(5'd7, 10'h0AA);
      do_read(1'b1, 5'd7);
      do_read(1'b1, 5'd3);

      // All three requesting out of reset: p1, then p2/vga alternate
      p1_addr = 5'd2; p1_wdata = 10'h2AA;
      p1_req = 1'b1; p2_req = 1'b1; vga_req = 1'b1;
      p2_addr = 5'd3; vga_addr = 5'd7;
      do_reset();
      exp_mem[2] = 10'h2AA;
      exp_wc = 3;
      gnt_q.push_back(3'b100);
      gnt_q.push_back(3'b010);
      gnt_q.push_back(3'b001);
      gnt_q.push_back(3'b010);
      gnt_q.push_back(3'b001);
      gnt_q.push_back(3'b010);
      for (int i = 0; i < 6; i++) begin
         n = 0;
         do begin
            tick();
            n++;
            g = {p1_gnt, p2_gnt, vga_gnt};
         end while (g == 3'b000 && n < 8);
         eg = gnt_q.pop_front();
         check("rr_order", {29'd0, g}, {29'd0, eg});
         if (p1_gnt) p1_req = 1'b0;
      end
      p2_req = 1'b0; vga_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("rr_wc", {26'd0, word_count}, exp_wc);
      do_read(1'b0, 5'd2);

      // word_count reaches 32 and does not drop on a lower rewrite
      do_write(5'd31, 10'h3FF);
      do_write(5'd0, 10'h001);
      check("wc_stays_32", {26'd0, word_count}, 32'd32);
      do_read(1'b1, 5'd31);

      // vga request visible only while S_WRITE is active is never served
      p1_addr = 5'd4; p1_wdata = 10'h123; p1_req = 1'b1;
      exp_mem[4] = 10'h123;
      tick();
      check("pulse_p1_gnt", {31'd0, p1_gnt}, 32'd1);
      p1_req = 1'b0;
      vga_req = 1'b1;
      tick();
      vga_req = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (vga_gnt) n++;
      end
      check("pulse_no_vga_gnt", n, 0);

      // Reset during S_DATA of a vga read discards it
      vga_addr = 5'd4; vga_req = 1'b1;
      tick();
      check("rst_rd_gnt", {31'd0, vga_gnt}, 32'd1);
      vga_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_wc = 0;
      check_all_zero("rst_in_data");
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (vga_rvalid || p2_rvalid) n++;
      end
      check("rst_no_rvalid", n, 0);
      do_read(1'b1, 5'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
